// File: rtl/bk_processor_p.sv
// -----------------------------------------------------------------------------
// bk_processor_p
//
// Purpose:
//   A small command processor built around a register file. It accepts one
//   command per cycle: ADD, SUB, AND, XOR, register WRITE and READ. An optional
//   multi-cycle shift-add multiplier (MUL) is also available. Results are
//   registered, so single-cycle ops show up the cycle after acceptance.
//
// Configuration:
//   BKP_MUL_EN - when defined, the shift-add multiplier and the MUL FSM state
//                are compiled in. When undefined, opcode 111 completes in one
//                cycle with a zero result and error=1, and ready never drops.
//
// Ports:
//   clk                      rising-edge clock
//   rst                      asynchronous active-high reset
//   cmdin[3+AW-1:0]          [2:0] opcode, [3+AW-1:3] register address
//   cmd_valid                command present this cycle
//   din_1, din_2, din_3      operands (din_3 is reserved, currently unused)
//   ready                    command can be accepted this cycle
//   dout_low, dout_high      result low / high halves (held between results)
//   out_valid                one-cycle pulse marking a new result
//   zero, error              result flags (error also pulses on a dropped cmd)
//
// Handshake:
//   A command is taken on a rising edge where cmd_valid && ready. When
//   cmd_valid is high while ready is low, the command is dropped and error
//   pulses for one cycle without out_valid; an in-flight MUL carries on.
// -----------------------------------------------------------------------------
module bk_processor_p #(
   parameter  int DW   = 8,
   parameter  int NREG = 16,
   localparam int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [3+AW-1:0] cmdin,
   input  logic            cmd_valid,
   input  logic [DW-1:0]   din_1,
   input  logic [DW-1:0]   din_2,
   input  logic [DW-1:0]   din_3,
   output logic            ready,
   output logic [DW-1:0]   dout_low,
   output logic [DW-1:0]   dout_high,
   output logic            out_valid,
   output logic            zero,
   output logic            error
);

   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_ADD   = 3'b001;
   localparam logic [2:0] OP_SUB   = 3'b010;
   localparam logic [2:0] OP_AND   = 3'b011;
   localparam logic [2:0] OP_XOR   = 3'b100;
   localparam logic [2:0] OP_WRITE = 3'b101;
   localparam logic [2:0] OP_READ  = 3'b110;
   localparam logic [2:0] OP_MUL   = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [2:0]    op;
   logic [AW-1:0] addr;
   logic          accept;
   logic          drop;
   logic          mul_start;
   logic          mul_last;

   // din_3 is part of the operand bus but no opcode consumes it yet.
   logic unused_din3;
   assign unused_din3 = ^din_3;

   assign op     = cmdin[2:0];
   assign addr   = cmdin[3+AW-1:3];
   assign accept = cmd_valid & ready;
   assign drop   = cmd_valid & ~ready;

   // ---------------------------------------------------------------------------
   // Register file
   // ---------------------------------------------------------------------------
   logic [DW-1:0] rf_q [NREG];
   logic          rf_we;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (rf_we) begin
         rf_q[addr] <= din_1;
      end
   end

   // ---------------------------------------------------------------------------
   // Multiplier datapath
   // ---------------------------------------------------------------------------
`ifdef BKP_MUL_EN
   localparam int CW = $clog2(DW) + 1;

   logic [2*DW-1:0] mcand_q;
   logic [2*DW-1:0] acc_q, acc_d;
   logic [DW-1:0]   mplier_q;
   logic [CW-1:0]   cnt_q;

   assign mul_start = accept && (op == OP_MUL);
   assign mul_last  = (state_q == ST_MUL) && (cnt_q == CW'(DW - 1));

   // One multiplier bit per cycle: the multiplicand walks left while the
   // multiplier walks right, so bit 0 of mplier_q is always the current bit.
   assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else if (mul_start) begin
         mcand_q  <= {{DW{1'b0}}, rf_q[addr]};
         mplier_q <= din_1;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else if (state_q == ST_MUL) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + 1'b1;
      end
   end
`else
   assign mul_start = 1'b0;
   assign mul_last  = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // FSM: state register / next state / outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (mul_start) state_d = ST_MUL;
         ST_MUL:  if (mul_last)  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ready = (state_q == ST_IDLE);
   end

   // ---------------------------------------------------------------------------
   // Result computation
   // ---------------------------------------------------------------------------
   logic [DW:0]   sum;
   logic          out_valid_d;
   logic [DW-1:0] dout_low_d;
   logic [DW-1:0] dout_high_d;
   logic          res_err_d;

   assign sum = {1'b0, din_1} + {1'b0, din_2};

   always_comb begin
      out_valid_d = 1'b0;
      dout_low_d  = '0;
      dout_high_d = '0;
      res_err_d   = 1'b0;
      rf_we       = 1'b0;
      if (accept) begin
         case (op)
            OP_ADD: begin
               out_valid_d = 1'b1;
               dout_low_d  = sum[DW-1:0];
               dout_high_d = DW'(sum[DW]);
            end
            OP_SUB: begin
               out_valid_d = 1'b1;
               dout_low_d  = din_1 - din_2;
               res_err_d   = (din_2 > din_1);
            end
            OP_AND: begin
               out_valid_d = 1'b1;
               dout_low_d  = din_1 & din_2;
            end
            OP_XOR: begin
               out_valid_d = 1'b1;
               dout_low_d  = din_1 ^ din_2;
            end
            OP_WRITE: begin
               out_valid_d = 1'b1;
               dout_low_d  = din_1;
               rf_we       = 1'b1;
            end
            // The register file updates on the WRITE's acceptance edge, so a
            // READ accepted one cycle later already sees the new value.
            OP_READ: begin
               out_valid_d = 1'b1;
               dout_low_d  = rf_q[addr];
            end
            OP_MUL: begin
`ifdef BKP_MUL_EN
               // Result is produced by the FSM on its final iteration.
`else
               out_valid_d = 1'b1;
               res_err_d   = 1'b1;
`endif
            end
            default: ; // OP_NOP: no result, outputs hold
         endcase
      end
`ifdef BKP_MUL_EN
      // ready is low during MUL, so this never collides with an accept.
      if (mul_last) begin
         out_valid_d              = 1'b1;
         {dout_high_d, dout_low_d} = acc_d;
      end
`endif
   end

   // ---------------------------------------------------------------------------
   // Output registers
   // ---------------------------------------------------------------------------
   logic          out_valid_q;
   logic [DW-1:0] dout_low_q;
   logic [DW-1:0] dout_high_q;
   logic          zero_q;
   logic          res_err_q;
   logic          drop_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         dout_low_q  <= '0;
         dout_high_q <= '0;
         zero_q      <= 1'b1;
         res_err_q   <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         drop_q      <= drop;
         if (out_valid_d) begin
            dout_low_q  <= dout_low_d;
            dout_high_q <= dout_high_d;
            zero_q      <= ({dout_high_d, dout_low_d} == '0);
            res_err_q   <= res_err_d;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign dout_low  = dout_low_q;
   assign dout_high = dout_high_q;
   assign zero      = zero_q;
   // The drop pulse overlays the held result flag, which reappears afterwards.
   assign error     = res_err_q | drop_q;

endmodule

// File: tb/tb_bk_processor_p.sv
// -----------------------------------------------------------------------------
// tb_bk_processor_p
//
// Directed and randomized stimulus for bk_processor_p. Expected results come
// from a behavioural model: integer arithmetic over an array standing in for
// the register file, plus the last held result. Works with and without
// BKP_MUL_EN.
// -----------------------------------------------------------------------------
module tb_bk_processor_p;

   localparam int DW   = 8;
   localparam int NREG = 16;
   localparam int AW   = 4;
   localparam int MASK = (1 << DW) - 1;
`ifdef BKP_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [3+AW-1:0] cmdin;
   logic            cmd_valid;
   logic [DW-1:0]   din_1, din_2, din_3;
   logic            ready;
   logic [DW-1:0]   dout_low, dout_high;
   logic            out_valid, zero, error;

   bk_processor_p #(.DW(DW), .NREG(NREG)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmdin     (cmdin),
      .cmd_valid (cmd_valid),
      .din_1     (din_1),
      .din_2     (din_2),
      .din_3     (din_3),
      .ready     (ready),
      .dout_low  (dout_low),
      .dout_high (dout_high),
      .out_valid (out_valid),
      .zero      (zero),
      .error     (error)
   );

   // ---------------------------------------------------------------------------
   // Clock / watchdog
   // ---------------------------------------------------------------------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Model state and bookkeeping
   // ---------------------------------------------------------------------------
   int checks = 0;
   int errors = 0;
   int model_rf [NREG];
   int exp_lo, exp_hi, exp_zero, exp_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NREG; i++) model_rf[i] = 0;
      exp_lo   = 0;
      exp_hi   = 0;
      exp_zero = 1;
      exp_err  = 0;
   endfunction

   // Returns whether the op produces a result; updates the held expectation.
   function automatic bit model_apply(input int op, input int addr, input int d1, input int d2);
      int lo, hi, e, p;
      lo = 0; hi = 0; e = 0; p = 0;
      case (op)
         0: return 1'b0;
         1: begin lo = (d1 + d2) & MASK; hi = (d1 + d2) >> DW; end
         2: begin lo = (d1 - d2) & MASK; e = (d2 > d1) ? 1 : 0; end
         3: lo = d1 & d2;
         4: lo = d1 ^ d2;
         5: begin model_rf[addr] = d1; lo = d1; end
         6: lo = model_rf[addr];
         default: begin
            if (MUL_EN) begin
               p  = model_rf[addr] * d1;
               lo = p & MASK;
               hi = p >> DW;
            end else begin
               e = 1;
            end
         end
      endcase
      exp_lo   = lo;
      exp_hi   = hi;
      exp_zero = (lo == 0 && hi == 0) ? 1 : 0;
      exp_err  = e;
      return 1'b1;
   endfunction

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int op, input int addr, input int d1, input int d2);
      logic [2:0]    o;
      logic [AW-1:0] a;
      o         = op[2:0];
      a         = addr[AW-1:0];
      cmdin     = {a, o};
      din_1     = d1[DW-1:0];
      din_2     = d2[DW-1:0];
      din_3     = DW'($urandom_range(0, MASK));
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic check_outputs(input string tag, input bit exp_v);
      check({tag, "_valid"}, out_valid, exp_v);
      check({tag, "_lo"},    dout_low,  exp_lo);
      check({tag, "_hi"},    dout_high, exp_hi);
      check({tag, "_zero"},  zero,      exp_zero);
      check({tag, "_err"},   error,     exp_err);
   endtask

   task automatic run_op(input int op, input int addr, input int d1, input int d2, input string tag);
      bit v;
      int n;
      v = model_apply(op, addr, d1, d2);
      issue(op, addr, d1, d2);
      if (MUL_EN && op == 7) begin
         n = 1;
         while (out_valid !== 1'b1 && n < DW + 6) begin
            tick();
            n++;
         end
         check({tag, "_lat"}, n, DW + 1);
      end
      check_outputs(tag, v);
      check({tag, "_ready"}, ready, 1);
   endtask

   task automatic apply_reset();
      rst       = 1'b1;
      cmd_valid = 1'b0;
      #1;
      check("rst_ready", ready, 1);
      check("rst_valid", out_valid, 0);
      tick();
      tick();
      rst = 1'b0;
      model_reset();
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int op, addr, d1, d2;
      cmdin     = '0;
      cmd_valid = 1'b0;
      din_1     = '0;
      din_2     = '0;
      din_3     = '0;
      rst       = 1'b1;
      #1;
      apply_reset();

      // Reset then idle.
      tick();
      tick();
      check_outputs("idle", 1'b0);
      check("idle_ready", ready, 1);

      // Arithmetic corners.
      run_op(1, 0, 'hF0, 'h20, "add_f0_20");
      tick();
      check_outputs("add_hold", 1'b0);
      run_op(1, 0, 'hFF, 'h01, "add_ff_01");
      run_op(2, 0, 'h05, 'h07, "sub_5_7");
      run_op(2, 0, 'h07, 'h07, "sub_7_7");
      run_op(3, 0, 'hA5, 'h5A, "and_zero");
      run_op(4, 0, 'hA5, 'h0F, "xor");
      run_op(0, 0, 'h12, 'h34, "nop");

      // Register file fill and read back.
      for (int i = 1; i <= 14; i++) run_op(5, i, i, 0, "wr");
      for (int i = 1; i <= 14; i++) run_op(6, i, 0, 0, "rd");
      run_op(5, 9, 'h55, 0, "wr55");
      run_op(6, 9, 0, 0, "rd55");

`ifdef BKP_MUL_EN
      // MUL with a command dropped mid-flight.
      run_op(5, 3, 'hFF, 0, "wr3_ff");
      issue(7, 3, 'hFF, 0);
      for (int c = 1; c <= DW; c++) begin
         check("mul_busy_ready", ready, 0);
         check("mul_busy_valid", out_valid, 0);
         if (c == 5) check("drop_err_pulse", error, 1);
         if (c == 6) check("drop_err_clear", error, exp_err);
         if (c == 6) check("drop_lo_held", dout_low, exp_lo);
         if (c == 4) begin
            cmdin     = {4'd1, 3'b001};
            din_1     = 8'h01;
            din_2     = 8'h02;
            cmd_valid = 1'b1;
         end else begin
            cmd_valid = 1'b0;
         end
         tick();
      end
      void'(model_apply(7, 3, 'hFF, 0));
      check_outputs("mul_ff_ff", 1'b1);
      check("mul_ff_ff_ready", ready, 1);
      tick();
      check("mul_pulse_once", out_valid, 0);

      // Reset partway through a MUL.
      run_op(5, 3, 'h33, 0, "wr3_33");
      issue(7, 3, 'h05, 0);
      tick();
      tick();
      tick();
      apply_reset();
      for (int c = 0; c < DW + 4; c++) begin
         check("abort_valid", out_valid, 0);
         check("abort_ready", ready, 1);
         tick();
      end
      check_outputs("abort_outs", 1'b0);
      run_op(6, 3, 0, 0, "abort_rd3");
`else
      // Opcode 111 without the multiplier.
      run_op(7, 3, 'hFF, 'h11, "mul_off");
      run_op(5, 3, 'h33, 0, "wr3_33");
      apply_reset();
      check_outputs("reset_outs", 1'b0);
      run_op(6, 3, 0, 0, "reset_rd3");
`endif

      // Randomized mix against the model.
      for (int k = 0; k < 300; k++) begin
         op   = $urandom_range(0, 7);
         addr = $urandom_range(0, NREG - 1);
         d1   = $urandom_range(0, MASK);
         d2   = $urandom_range(0, MASK);
         run_op(op, addr, d1, d2, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
